// File: rtl/i2c_byte_engine_if.sv
// Command/response handshake and open-drain bus pins of the I2C byte engine.
// The host side uses the master modport; the engine uses the slave modport.
interface i2c_byte_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_txbyte;
  logic       cmd_nack;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       busy;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic       scl_oe;

  modport master (
    output cmd_valid, cmd_op, cmd_txbyte, cmd_nack, sda_in, scl_in,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ack, busy, sda_oe, scl_oe
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_txbyte, cmd_nack, sda_in, scl_in,
    output cmd_ready, rsp_valid, rsp_data, rsp_ack, busy, sda_oe, scl_oe
  );
endinterface

// File: rtl/i2c_byte_engine.sv
// I2C master engine running one START/WRITE/READ/STOP command at a time; I2C_CLOCK_STRETCH_EN adds SCL stretching.
// Latency 4*CLK_DIV+1 (START/STOP) or 36*CLK_DIV+1 (WRITE/READ); cmd_ready is low for the whole operation.
module i2c_byte_engine #(
  parameter int CLK_DIV = 250
) (
  input logic              clk,
  input logic              resetn,
  i2c_byte_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, START_S, BYTE_S, STOP_S} state_t;

  localparam logic [1:0]  OP_START = 2'd0;
  localparam logic [1:0]  OP_WRITE = 2'd1;
  localparam logic [1:0]  OP_READ  = 2'd2;
  localparam logic [1:0]  OP_STOP  = 2'd3;
  localparam logic [15:0] RELOAD   = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  tx_q, tx_d;
  logic        nack_q, nack_d;
  logic [7:0]  sh_q, sh_d;
  logic        ack_q, ack_d;
  logic        ready_en_q, ready_en_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_ack_q, rsp_ack_d;
  logic        sda_oe_q, sda_oe_d;
  logic        scl_oe_q, scl_oe_d;

  logic ready;
  logic accept;
  logic stall;
  logic qend;

  // A slave holding SCL low while we release it freezes the quarter timer.
`ifdef I2C_CLOCK_STRETCH_EN
  assign stall = (phase_q != 2'd0) && !scl_oe_q && !bus.scl_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = bus.scl_in;
  assign stall         = 1'b0;
`endif

  assign ready  = (state_q == IDLE) && ready_en_q;
  assign accept = bus.cmd_valid && ready;
  assign qend   = (cnt_q == 16'd0) && !stall;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    tx_d        = tx_q;
    nack_d      = nack_q;
    sh_d        = sh_q;
    ack_d       = ack_q;
    ready_en_d  = 1'b1;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ack_d   = rsp_ack_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = scl_oe_q;

    if (state_q == IDLE) begin
      if (accept) begin
        op_d    = bus.cmd_op;
        tx_d    = bus.cmd_txbyte;
        nack_d  = bus.cmd_nack;
        phase_d = 2'd0;
        bit_d   = 4'd0;
        cnt_d   = RELOAD;
        sh_d    = 8'h00;
        ack_d   = 1'b0;
        case (bus.cmd_op)
          OP_START: state_d = START_S;
          OP_STOP:  state_d = STOP_S;
          default:  state_d = BYTE_S;
        endcase
      end
    end else begin
      if (!stall) cnt_d = cnt_q - 16'd1;
      // The slave's SDA level is taken on the final cycle of the SCL-high quarter Q2.
      if ((state_q == BYTE_S) && (phase_q == 2'd2) && qend) begin
        if (bit_q[3]) ack_d = bus.sda_in;
        else          sh_d  = {sh_q[6:0], bus.sda_in};
      end
      if (qend) begin
        cnt_d   = RELOAD;
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if ((state_q == BYTE_S) && !bit_q[3]) begin
            bit_d = bit_q + 4'd1;
          end else begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_data_d  = (op_q == OP_READ) ? sh_q : 8'h00;
            case (op_q)
              OP_WRITE: rsp_ack_d = ack_q;
              OP_READ:  rsp_ack_d = nack_q;
              default:  rsp_ack_d = 1'b0;
            endcase
          end
        end
      end
    end

    // Pin drive follows the next state so the registered pins line up with the phase they belong to.
    case (state_d)
      START_S: begin
        scl_oe_d = (phase_d == 2'd3);
        sda_oe_d = (phase_d >= 2'd2);
      end
      STOP_S: begin
        scl_oe_d = (phase_d == 2'd0);
        sda_oe_d = (phase_d != 2'd3);
      end
      BYTE_S: begin
        scl_oe_d = (phase_d == 2'd0);
        if (bit_d[3])                sda_oe_d = (op_d == OP_READ) ? ~nack_d : 1'b0;
        else if (op_d == OP_READ)    sda_oe_d = 1'b0;
        else                         sda_oe_d = ~tx_d[~bit_d[2:0]];
      end
      default: begin
        if (state_q == BYTE_S) scl_oe_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      cnt_q       <= 16'd0;
      op_q        <= 2'd0;
      tx_q        <= 8'h00;
      nack_q      <= 1'b0;
      sh_q        <= 8'h00;
      ack_q       <= 1'b0;
      ready_en_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_ack_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      tx_q        <= tx_d;
      nack_q      <= nack_d;
      sh_q        <= sh_d;
      ack_q       <= ack_d;
      ready_en_q  <= ready_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ack_q   <= rsp_ack_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
    end
  end

  assign bus.cmd_ready = ready;
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ack   = rsp_ack_q;
  assign bus.sda_oe    = sda_oe_q;
  assign bus.scl_oe    = scl_oe_q;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine at CLK_DIV=4 with a pulled-up bus and a simple slave model.
// Responses are checked against a scoreboard of expected latency/data/ack.
module tb_i2c_byte_engine;
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;
`ifdef I2C_CLOCK_STRETCH_EN
  localparam int STRETCH_LAT = 155;
`else
  localparam int STRETCH_LAT = 145;
`endif

  typedef struct {
    int         lat;
    logic [7:0] data;
    logic       ack;
  } exp_t;

  logic clk;
  logic resetn;
  i2c_byte_engine_if bus();

  i2c_byte_engine #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   acc_q[$];

  logic       slave_on = 1'b0;
  logic [8:0] slave_bits = 9'h1FF;
  logic       slave_low = 1'b0;
  logic       scl_force = 1'b0;
  int         rise_idx = 0;
  logic       prev_scl_oe = 1'b0;
  logic [7:0] seen_w = 8'h00;
  logic       oe8 = 1'b0;
  logic       prev_sda_l = 1'b1;
  logic       prev_scl_l = 1'b1;
  int         sda_fall_hi = 0;
  int         sda_rise_hi = 0;

  assign bus.sda_in = ~bus.sda_oe & ~slave_low;
  assign bus.scl_in = ~bus.scl_oe & ~scl_force;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: acceptance times and expected results pop in order on each rsp_valid.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    if (resetn && bus.cmd_valid && bus.cmd_ready) acc_q.push_back(cyc);
    if (bus.rsp_valid) begin
      checks++;
      assert (exp_q.size() > 0 && acc_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_rsp: got rsp_valid expected none");
      end
      if (exp_q.size() > 0 && acc_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("rsp_latency", 32'(cyc - a), 32'(e.lat));
        chk("rsp_data", {24'h0, bus.rsp_data}, {24'h0, e.data});
        chk("rsp_ack", {31'h0, bus.rsp_ack}, {31'h0, e.ack});
      end
    end
  end

  // Slave: updates its SDA pull at each SCL rise, records master data bits and bit-8 drive.
  always @(negedge clk) begin
    logic sda_l, scl_l;
    if (!slave_on) begin
      rise_idx  = 0;
      slave_low = 1'b0;
    end else if (prev_scl_oe && !bus.scl_oe) begin
      if (rise_idx < 8) seen_w[7-rise_idx] = ~bus.sda_oe & ~slave_low;
      if (rise_idx == 8) oe8 = bus.sda_oe;
      slave_low = (rise_idx < 9) ? ~slave_bits[rise_idx] : 1'b0;
      rise_idx++;
    end
    prev_scl_oe = bus.scl_oe;
    sda_l = ~bus.sda_oe & ~slave_low;
    scl_l = ~bus.scl_oe & ~scl_force;
    if (prev_scl_l && scl_l && prev_sda_l && !sda_l) sda_fall_hi++;
    if (prev_scl_l && scl_l && !prev_sda_l && sda_l) sda_rise_hi++;
    prev_sda_l = sda_l;
    prev_scl_l = scl_l;
  end

  function automatic logic [8:0] slave_pat(input logic [7:0] b, input logic bit8);
    logic [8:0] p;
    for (int k = 0; k < 8; k++) p[k] = b[7-k];
    p[8] = bit8;
    return p;
  endfunction

  task automatic slave_arm(input logic [8:0] bits);
    slave_on = 1'b0;
    @(negedge clk);
    #1;
    slave_bits = bits;
    slave_on   = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] tx, input logic nk,
                      input int lat, input logic [7:0] d, input logic a);
    int n;
    exp_q.push_back('{lat, d, a});
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = op;
    bus.cmd_txbyte = tx;
    bus.cmd_nack   = nk;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 300);
    chk("send_ready", {31'h0, bus.cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.cmd_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_drained", 32'(exp_q.size()), 32'h0);
    slave_on = 1'b0;
  endtask

  initial begin
    int n;
    resetn         = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 2'd0;
    bus.cmd_txbyte = 8'h00;
    bus.cmd_nack   = 1'b0;
    #3 resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_pins", {30'h0, bus.sda_oe, bus.scl_oe}, 32'h0);
    chk("reset_rsp", {22'h0, bus.rsp_valid, bus.rsp_data, bus.rsp_ack}, 32'h0);
    chk("reset_busy_ready", {30'h0, bus.busy, bus.cmd_ready}, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    #1 chk("ready_before_edge", {31'h0, bus.cmd_ready}, 32'h0);
    @(posedge clk);
    #1 chk("ready_after_edge", {31'h0, bus.cmd_ready}, 32'h1);

    // START: SDA falls while SCL is high
    sda_fall_hi = 0; sda_rise_hi = 0;
    send(OP_START, 8'h00, 1'b0, 17, 8'h00, 1'b0);
    wait_done();
    chk("start_sda_fall", 32'(sda_fall_hi), 32'h1);
    chk("start_sda_rise", 32'(sda_rise_hi), 32'h0);
    chk("start_idle_pins", {30'h0, bus.sda_oe, bus.scl_oe}, 32'h3);

    // WRITE 0xA5, slave acks
    slave_arm(slave_pat(8'hFF, 1'b0));
    send(OP_WRITE, 8'hA5, 1'b0, 145, 8'h00, 1'b0);
    wait_done();
    chk("write_pattern", {24'h0, seen_w}, 32'hA5);
    chk("write_bit8_release", {31'h0, oe8}, 32'h0);
    chk("write_idle_scl", {31'h0, bus.scl_oe}, 32'h1);

    // READ 0x3C with NACK
    slave_arm(slave_pat(8'h3C, 1'b1));
    send(OP_READ, 8'h00, 1'b1, 145, 8'h3C, 1'b1);
    wait_done();
    chk("read_nack_oe8", {31'h0, oe8}, 32'h0);

    // repeated START: previous response must hold while busy
    send(OP_START, 8'h00, 1'b0, 17, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    chk("rsp_hold_data", {24'h0, bus.rsp_data}, 32'h3C);
    chk("busy_mid_op", {30'h0, bus.busy, bus.cmd_ready}, 32'h2);
    wait_done();

    // READ 0x81 with ACK
    slave_arm(slave_pat(8'h81, 1'b1));
    send(OP_READ, 8'h00, 1'b0, 145, 8'h81, 1'b0);
    wait_done();
    chk("read_ack_oe8", {31'h0, oe8}, 32'h1);

    // WRITE 0x5A, slave does not ack
    slave_arm(slave_pat(8'hFF, 1'b1));
    send(OP_WRITE, 8'h5A, 1'b0, 145, 8'h00, 1'b1);
    wait_done();
    chk("write5a_pattern", {24'h0, seen_w}, 32'h5A);

    // WRITE with cmd_valid held; STOP queued behind it
    slave_arm(slave_pat(8'hFF, 1'b0));
    exp_q.push_back('{145, 8'h00, 1'b0});
    exp_q.push_back('{17, 8'h00, 1'b0});
    @(posedge clk);
    #1;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = OP_WRITE;
    bus.cmd_txbyte = 8'h33;
    bus.cmd_nack   = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 300);
    chk("held_first_ready", {31'h0, bus.cmd_ready}, 32'h1);
    @(posedge clk);
    #1 bus.cmd_op = OP_STOP;
    sda_fall_hi = 0; sda_rise_hi = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 300);
    chk("held_busy_cycles", 32'(n), 32'd145);
    chk("held_accept_on_rsp", {31'h0, bus.rsp_valid}, 32'h1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done();
    chk("stop_sda_rise", 32'(sda_rise_hi), 32'h1);
    chk("stop_sda_fall", 32'(sda_fall_hi), 32'h0);
    chk("stop_released", {30'h0, bus.sda_oe, bus.scl_oe}, 32'h0);

    // SCL held low by the slave for 10 cycles during bit 2
    slave_arm(slave_pat(8'hFF, 1'b0));
    send(OP_WRITE, 8'hC3, 1'b0, STRETCH_LAT, 8'h00, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (rise_idx < 3 && n < 300);
    chk("stretch_reach_bit2", 32'(rise_idx), 32'd3);
    scl_force = 1'b1;
    repeat (10) @(posedge clk);
    #1 scl_force = 1'b0;
    wait_done();
    chk("stretch_pattern", {24'h0, seen_w}, 32'hC3);

    // reset in the middle of a WRITE, at bit 4 Q0
    slave_arm(slave_pat(8'hFF, 1'b0));
    send(OP_WRITE, 8'h00, 1'b0, 145, 8'h00, 1'b0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(rise_idx >= 4 && bus.scl_oe) && n < 300);
    chk("abort_pre_pins", {30'h0, bus.sda_oe, bus.scl_oe}, 32'h3);
    resetn   = 1'b0;
    slave_on = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("abort_pins", {30'h0, bus.sda_oe, bus.scl_oe}, 32'h0);
    chk("abort_state", {29'h0, bus.busy, bus.cmd_ready, bus.rsp_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    #1 chk("abort_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
    @(posedge clk);
    #1 chk("abort_ready_high", {31'h0, bus.cmd_ready}, 32'h1);
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
